// File: rtl/score_keeper.sv
// score_keeper: BASPONG match state. Edge-qualified point requests feed per-player binary and
// BCD scores, with a serve lockout after each point, win detection and a game-over state.
module score_keeper #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned WIN_BY      = 1,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic                            clk_50,
    input  logic                            reset,
    input  logic [NUM_PLAYERS-1:0]          score_req,
    input  logic                            new_game,
    output logic [NUM_PLAYERS*DIGITS*4-1:0] bcd,
    output logic                            serve_enable,
    output logic                            point_strobe,
    output logic [1:0]                      last_scorer,
    output logic                            game_over,
    output logic [NUM_PLAYERS-1:0]          winner
);

    localparam int unsigned SCORE_RANGE = 10 ** DIGITS;
    localparam int unsigned BIN_W       = $clog2(SCORE_RANGE);
    localparam int unsigned MAX_SCORE   = SCORE_RANGE - 1;
    localparam int unsigned HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BIN_W-1:0]  BIN_MAX   = BIN_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HOLD,
        ST_OVER
    } state_t;

    state_t                                  state_q, state_d;
    logic [NUM_PLAYERS-1:0]                  req_q, req_d;
    logic [NUM_PLAYERS-1:0][BIN_W-1:0]       bin_q, bin_d;
    logic [NUM_PLAYERS-1:0][DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [HOLD_W-1:0]                       hold_cnt_q, hold_cnt_d;
    logic                                    serve_enable_q, serve_enable_d;
    logic                                    point_strobe_q, point_strobe_d;
    logic [1:0]                              last_scorer_q, last_scorer_d;
    logic                                    game_over_q, game_over_d;
    logic [NUM_PLAYERS-1:0]                  winner_q, winner_d;

    logic [NUM_PLAYERS-1:0]                  rise_c;
    logic [NUM_PLAYERS-1:0]                  pick_c;
    logic [1:0]                              pick_idx_c;
    logic [NUM_PLAYERS-1:0][BIN_W-1:0]       nxt_bin_c;
    logic [NUM_PLAYERS-1:0][DIGITS-1:0][3:0] nxt_bcd_c;
    logic [NUM_PLAYERS-1:0]                  win_c;

    // Rising-edge detect and lowest-index arbitration (x & -x isolates the lowest set bit).
    always_comb begin
        req_d      = score_req;
        rise_c     = score_req & ~req_q;
        pick_c     = rise_c & (~rise_c + NUM_PLAYERS'(1));
        pick_idx_c = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (pick_c[p]) begin
                pick_idx_c = 2'(p);
            end
        end
    end

    // Candidate post-point score for every player; saturates at all-nines.
    always_comb begin
        logic carry;
        carry     = 1'b0;
        nxt_bin_c = bin_q;
        nxt_bcd_c = bcd_q;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            carry = 1'b1;
            if (bin_q[p] != BIN_MAX) begin
                nxt_bin_c[p] = bin_q[p] + BIN_W'(1);
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if (carry) begin
                        if (bcd_q[p][d] == 4'd9) begin
                            nxt_bcd_c[p][d] = 4'd0;
                        end else begin
                            nxt_bcd_c[p][d] = bcd_q[p][d] + 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Win test on the candidate score against every other player's current score.
    always_comb begin
        win_c = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            win_c[p] = (32'(nxt_bin_c[p]) >= WIN_SCORE);
            for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
                if ((q != p) && (32'(nxt_bin_c[p]) < (32'(bin_q[q]) + WIN_BY))) begin
                    win_c[p] = 1'b0;
                end
            end
        end
    end

    // Match FSM next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        bin_d          = bin_q;
        bcd_d          = bcd_q;
        winner_d       = winner_q;
        last_scorer_d  = last_scorer_q;
        point_strobe_d = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (|rise_c) begin
                    point_strobe_d = 1'b1;
                    last_scorer_d  = pick_idx_c;
                    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                        if (pick_c[p]) begin
                            bin_d[p] = nxt_bin_c[p];
                            bcd_d[p] = nxt_bcd_c[p];
                        end
                    end
                    if (|(pick_c & win_c)) begin
                        state_d  = ST_OVER;
                        winner_d = pick_c;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase

        // A restart overrides everything, including a same-cycle point.
        if (new_game) begin
            state_d        = ST_PLAY;
            hold_cnt_d     = '0;
            bin_d          = '0;
            bcd_d          = '0;
            winner_d       = '0;
            last_scorer_d  = last_scorer_q;
            point_strobe_d = 1'b0;
        end

        serve_enable_d = (state_d == ST_PLAY);
        game_over_d    = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q        <= ST_PLAY;
            req_q          <= '1;
            bin_q          <= '0;
            bcd_q          <= '0;
            hold_cnt_q     <= '0;
            serve_enable_q <= 1'b1;
            point_strobe_q <= 1'b0;
            last_scorer_q  <= '0;
            game_over_q    <= 1'b0;
            winner_q       <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            bin_q          <= bin_d;
            bcd_q          <= bcd_d;
            hold_cnt_q     <= hold_cnt_d;
            serve_enable_q <= serve_enable_d;
            point_strobe_q <= point_strobe_d;
            last_scorer_q  <= last_scorer_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign bcd          = bcd_q;
    assign serve_enable = serve_enable_q;
    assign point_strobe = point_strobe_q;
    assign last_scorer  = last_scorer_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: doc/score_keeper.md
# score_keeper

Parametrised multi-player score and match-state unit for BASPONG. It takes per-player point requests from the animation/collision logic and keeps a binary and a BCD score per player. It enforces a post-point hold (serve lockout), detects a match win with a configurable target and margin, and drives the packed BCD bus consumed by the seven-segment driver. It generalises the fixed two-player, two-digit, unbounded counter to N players, D digits, edge-qualified inputs and a game-over state.

## Interface
- NUM_PLAYERS, 2, number of players/score channels (2..4)
- DIGITS, 2, BCD digits per player (1..4)
- WIN_SCORE, 11, points needed to win; must be ≤ 10^DIGITS−1
- WIN_BY, 1, required lead over every other player at win (1 = first to WIN_SCORE, 2 = deuce rule)
- HOLD_CYCLES, 50_000_000, serve-lockout length after each point (1 s at 50 MHz); ≥ 1

- clk_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- score_req  in  NUM_PLAYERS  per-player point request, level; only 0→1 transitions count (synchronous to clk_50)
- new_game  in  1  single-cycle pulse; clears scores and restarts the match
- bcd  out  NUM_PLAYERS*DIGITS*4  packed scores; player p digit d at bits [(p*DIGITS+d)*4 +: 4], d=0 is units
- serve_enable  out  1  high when the ball may be served (state PLAY)
- point_strobe  out  1  one-cycle pulse on each accepted point
- last_scorer  out  2  index of the most recent accepted scorer
- game_over  out  1  high in state OVER
- winner  out  NUM_PLAYERS  one-hot winner, valid while game_over=1, else 0

## Operation
- Edge detect: req_q registers score_req every cycle; rise = score_req & ~req_q. req_q resets to all-ones, so a request held high through reset is not counted.
- States: PLAY, HOLD, OVER. Reset → PLAY.
- PLAY: if any rise bit is set, accept the lowest-index set bit p; drop the others, with no queuing.
  - Increment bin[p] and bcd[p]. BCD carries: a digit at 9 wraps to 0 and increments the next digit. At all-nines the score saturates and no increment occurs, but the point is still accepted.
  - Win test uses the post-increment value: bin[p] ≥ WIN_SCORE and bin[p] − bin[q] ≥ WIN_BY for every q ≠ p.
  - On a win, go to OVER and set winner bit p. Otherwise go to HOLD and load hold_cnt = HOLD_CYCLES−1.
- HOLD: rises are ignored. hold_cnt decrements each cycle; at 0, go to PLAY.
- OVER: rises are ignored. Scores, winner and last_scorer are frozen.
- new_game (any state): clear all bin/bcd to 0, winner to 0 and hold_cnt; go to PLAY. new_game wins over a same-cycle rise, and that rise is discarded.
- Binary counter width: $clog2(10^DIGITS). bin and bcd always represent the same value.

## Timing
- Reset values: bcd=0, serve_enable=1, point_strobe=0, last_scorer=0, game_over=0, winner=0, state PLAY, req_q=all ones.
- All outputs are registered.
- Rise sampled at edge k (score_req=1 at k, 0 at k−1):
  - bcd, last_scorer and point_strobe update at edge k.
  - serve_enable falls at edge k.
  - For a winning point, game_over and winner assert at edge k.
- HOLD lasts exactly HOLD_CYCLES cycles. serve_enable returns high at edge k+HOLD_CYCLES.
- new_game at edge k: outputs read cleared and serve_enable=1 after edge k.
- Reset asserted mid-HOLD or in OVER: immediate return to reset values, with no clock needed.
- Request held high is counted once. It must drop for ≥1 cycle before it can score again.

## Test plan
- Defaults with HOLD_CYCLES=4: pulse score_req[0] ten times, waiting for serve_enable between pulses → bcd player0 = 0x10, ten point_strobes, each followed by exactly 4 cycles of serve_enable=0.
- Simultaneous score_req=2'b11 in PLAY → only player 0 increments, last_scorer=0. Player 1 request held high through HOLD → not counted until it is deasserted and reasserted.
- WIN_SCORE=11, WIN_BY=2: drive the score to 10–10, then p0 scores to 11–10 (no win, HOLD), p1 scores to 11–11, p0 scores twice to 13–11 → game_over=1, winner=2'b01, serve_enable=0. Further requests are ignored.
- In OVER, pulse new_game together with score_req[1] rising → all scores 0, game_over=0, serve_enable=1, no point counted.
- DIGITS=1, WIN_SCORE=9, NUM_PLAYERS=3: p2 scores 9 → game_over, winner=3'b100, bcd[11:8]=9. Assert reset mid-HOLD on an earlier run → all outputs return to reset values asynchronously.
